// File: rtl/multi_digit_display.sv
// Multiplexed seven-segment driver for NUM_DIGITS digits.
// A free-running double-dabble engine converts the selected binary value to BCD
// and commits complete results to a digit buffer; a prescaled scan walks the
// digits and registers the active-low anode and segment outputs one digit per tick.
module multi_digit_display #(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = 16,
    parameter int DIV        = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VAL_W-1:0]        value_a,
    input  logic [VAL_W-1:0]        value_b,
    input  logic                    sel_b,
    input  logic                    msg_en,
    input  logic [4*NUM_DIGITS-1:0] msg_code,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg
);

    // Smallest value that no longer fits in NUM_DIGITS decimal digits.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Segment pattern {g,f,e,d,c,b,a}, active low, for each glyph code.
    function automatic logic [6:0] glyph_to_seg(input logic [3:0] g);
        case (g)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            4'd10:   return 7'h47;   // L
            4'd11:   return 7'h06;   // E
            4'd12:   return 7'h3F;   // -
            default: return 7'h7F;   // blank
        endcase
    endfunction

    localparam int CNT_W     = $clog2(DIV);
    localparam int POS_W     = $clog2(NUM_DIGITS);
    localparam int SCNT_W    = $clog2(VAL_W);
    // Accumulator always has room for every BCD digit of a VAL_W-bit value,
    // and at least the displayed digits.
    localparam int ACC_DIGS  = ((VAL_W / 3 + 1) > NUM_DIGITS) ? (VAL_W / 3 + 1) : NUM_DIGITS;
    localparam int ACC_W     = 4 * ACC_DIGS;
    localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    // ------------------------------------------------------------------
    // Refresh prescaler and digit position
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             tick;

    assign tick      = (div_cnt_q == CNT_W'(DIV - 1));
    assign div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
    assign pos_d     = (pos_q == POS_W'(NUM_DIGITS - 1)) ? '0 : pos_q + POS_W'(1);

    // Prescaler counts every cycle; scan position steps once per tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            pos_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            if (tick) begin
                pos_q <= pos_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double-dabble converter
    // ------------------------------------------------------------------
    conv_state_t               state_q;
    logic [VAL_W-1:0]          bin_q;
    logic [ACC_W-1:0]          acc_q;
    logic [ACC_W-1:0]          acc_adj;
    logic [SCNT_W-1:0]         shift_cnt_q;
    logic                      ovf_work_q;
    logic [4*NUM_DIGITS-1:0]   bcd_q;
    logic                      ovf_q;
    logic [VAL_W-1:0]          sample_val;

    assign sample_val = sel_b ? value_b : value_a;

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
    for (genvar gi = 0; gi < ACC_DIGS; gi++) begin : g_adj
        logic [3:0] nib;
        assign nib                 = acc_q[4*gi +: 4];
        assign acc_adj[4*gi +: 4]  = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    // Converter FSM: the committed buffer and overflow flag change only in COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            acc_q       <= '0;
            shift_cnt_q <= '0;
            ovf_work_q  <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    bin_q       <= sample_val;
                    acc_q       <= '0;
                    shift_cnt_q <= '0;
                    ovf_work_q  <= (64'(sample_val) >= OVF_LIMIT);
                    state_q     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    acc_q       <= ACC_W'({acc_adj, bin_q[VAL_W-1]});
                    bin_q       <= {bin_q[VAL_W-2:0], 1'b0};
                    shift_cnt_q <= shift_cnt_q + SCNT_W'(1);
                    if (shift_cnt_q == SCNT_W'(VAL_W - 1)) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    bcd_q   <= acc_q[4*NUM_DIGITS-1:0];
                    ovf_q   <= ovf_work_q;
                    state_q <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Glyph selection per digit
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0]   digit_nz;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [4*NUM_DIGITS-1:0] glyph_flat;
    logic [3:0]              cur_glyph;

    // A digit is a leading zero when it and everything above it are zero;
    // digit 0 is never blanked so that a value of 0 still shows '0'.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_glyph
        assign digit_nz[gi] = |bcd_q[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lz_blank[gi] = ~(|digit_nz[NUM_DIGITS-1:gi]);
        end
        assign glyph_flat[4*gi +: 4] =
            msg_en                    ? msg_code[4*gi +: 4] :
            ovf_q                     ? 4'd12               :
            (blank_lz && lz_blank[gi]) ? 4'd15               :
                                        bcd_q[4*gi +: 4];
    end

    assign cur_glyph = glyph_flat[{pos_q, 2'b00} +: 4];

    // ------------------------------------------------------------------
    // Registered display outputs
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] an_q;
    logic [7:0]            seg_q;

    // Latch the digit at the current position on each tick; all blank in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= 8'hFF;
        end else if (tick) begin
            an_q  <= ~(NUM_DIGITS'(1) << pos_q);
            seg_q <= {~dp_mask[pos_q], glyph_to_seg(cur_glyph)};
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Directed bench for multi_digit_display with NUM_DIGITS=4, VAL_W=16, DIV=4.
module tb_multi_digit_display;

    localparam int ND = 4;
    localparam int VW = 16;
    localparam int DV = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [VW-1:0]   value_a;
    logic [VW-1:0]   value_b;
    logic            sel_b;
    logic            msg_en;
    logic [4*ND-1:0] msg_code;
    logic            blank_lz;
    logic [ND-1:0]   dp_mask;
    logic [ND-1:0]   an;
    logic [7:0]      seg;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    multi_digit_display #(
        .NUM_DIGITS(ND),
        .VAL_W     (VW),
        .DIV       (DV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value_a  (value_a),
        .value_b  (value_b),
        .sel_b    (sel_b),
        .msg_en   (msg_en),
        .msg_code (msg_code),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .an       (an),
        .seg      (seg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Pulse reset; returns just after the last edge that sees rst=1.
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Let at least two full conversions and several ticks pass.
    task automatic settle();
        repeat (40) @(posedge clk);
        #1;
    endtask

    // Align to a fresh digit-0 refresh and check one full scan of 4 digits.
    task automatic check_round(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] exp_seg [ND];
        logic [3:0] exp_an;
        int         w;
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
        w = 0;
        @(negedge clk);
        while (an == 4'hE && w < 64) begin
            @(negedge clk);
            w++;
        end
        while (an != 4'hE && w < 128) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("%s_an0", tag), an, 4'hE);
        chk($sformatf("%s_seg0", tag), seg, exp_seg[0]);
        for (int d = 1; d < ND; d++) begin
            repeat (DV) @(negedge clk);
            exp_an = ~(4'b0001 << d);
            chk($sformatf("%s_an%0d", tag, d), an, exp_an);
            chk($sformatf("%s_seg%0d", tag, d), seg, exp_seg[d]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst      = 1'b1;
        value_a  = 16'd1234;
        value_b  = 16'd0;
        sel_b    = 1'b0;
        msg_en   = 1'b0;
        msg_code = '0;
        blank_lz = 1'b0;
        dp_mask  = '0;

        // Reset state and first-tick timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 8'hFF);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_tick_an", an, 4'hF);
        @(negedge clk);
        chk("first_tick_an", an, 4'hE);
        chk("first_tick_seg", seg, 8'hC0);

        // Plain number.
        settle();
        check_round("v1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // Overflow boundary.
        value_a = 16'd10000;
        settle();
        check_round("v10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        value_a = 16'd9999;
        settle();
        check_round("v9999", 8'h90, 8'h90, 8'h90, 8'h90);

        // Leading-zero blanking and decimal point.
        value_a  = 16'd7;
        blank_lz = 1'b1;
        dp_mask  = 4'b0001;
        settle();
        check_round("v7_lz_dp", 8'h78, 8'hFF, 8'hFF, 8'hFF);
        value_a = 16'd0;
        dp_mask = 4'b0000;
        settle();
        check_round("v0_lz", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        value_a = 16'd305;
        settle();
        check_round("v305_lz", 8'h92, 8'hC0, 8'hB0, 8'hFF);

        // Message overrides overflow and blanking.
        value_a  = 16'd10000;
        msg_en   = 1'b1;
        msg_code = 16'hA05B;
        settle();
        check_round("msg", 8'h86, 8'h92, 8'hC0, 8'hC7);

        // value_b selection.
        msg_en   = 1'b0;
        blank_lz = 1'b0;
        value_b  = 16'd56;
        sel_b    = 1'b1;
        settle();
        check_round("selb56", 8'h82, 8'h92, 8'hC0, 8'hC0);
        sel_b = 1'b0;

        // Input change mid-conversion: LOAD at edges 2,20,38,56; change after edge 41.
        value_a = 16'd1111;
        do_reset();
        repeat (41) @(posedge clk);
        #1 value_a = 16'd2222;
        @(posedge clk);
        bad = 0;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (seg !== 8'hF9) bad++;
        end
        chk("hold_1111_bad", bad, 0);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (seg !== 8'hA4) bad++;
        end
        chk("show_2222_bad", bad, 0);

        // One-cycle reset in the middle of SHIFT of the second conversion.
        value_a = 16'd1234;
        do_reset();
        repeat (25) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_an", an, 4'hF);
        chk("midrst_seg", seg, 8'hFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_pre_tick_an", an, 4'hF);
        @(negedge clk);
        chk("midrst_tick_an", an, 4'hE);
        chk("midrst_buf0_seg", seg, 8'hC0);
        repeat (8) @(negedge clk);
        chk("midrst_nostale_an", an, 4'hB);
        chk("midrst_nostale_seg", seg, 8'hC0);
        repeat (8) @(negedge clk);
        chk("midrst_valid_an", an, 4'hE);
        chk("midrst_valid_seg", seg, 8'h99);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/multi_digit_display.md
MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter VAL_W, default 16, binary value width (legal 4..32).
REQ-003 SHALL have parameter DIV, default 50000, clk cycles per digit refresh tick (legal >= 2).
REQ-004 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port value_a  in  VAL_W  unsigned binary value A.
REQ-007 SHALL have port value_b  in  VAL_W  unsigned binary value B.
REQ-008 SHALL have port sel_b  in  1  1 = display value_b, 0 = value_a.
REQ-009 SHALL have port msg_en  in  1  1 = display msg_code instead of a number.
REQ-010 SHALL have port msg_code  in  4*NUM_DIGITS  per-digit glyph codes; bits [4i+3:4i] drive digit i.
REQ-011 SHALL have port blank_lz  in  1  1 = blank leading zeros.
REQ-012 SHALL have port dp_mask  in  NUM_DIGITS  1 = light decimal point of digit i.
REQ-013 SHALL have port an  out  NUM_DIGITS  active-low digit enables; an[0] = rightmost, least significant digit.
REQ-014 SHALL have port seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-015 Glyph codes SHALL be: 0-9 decimal digits, 10 'L', 11 'E', 12 '-', 13-15 blank.
REQ-016 Segment patterns before the dp bit SHALL be: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 L=C7 E=86 '-'=BF blank=FF (hex, seg with dp=1); seg[7] SHALL be ~dp_mask[pos].
REQ-017 Prescaler SHALL count 0..DIV-1 and wrap; a tick is asserted in the cycle the count equals DIV-1.
REQ-018 On each tick, pos SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-019 an and seg SHALL be registered and update in the cycle after each tick; an SHALL be one-hot low at bit pos; all other an bits SHALL be 1.
REQ-020 Converter SHALL be a sequential shift-add-3 (double-dabble) engine: IDLE -> LOAD -> SHIFT (VAL_W cycles) -> COMMIT -> LOAD, running continuously.
REQ-021 LOAD SHALL sample (sel_b ? value_b : value_a) once; input changes after LOAD SHALL NOT affect the running conversion.
REQ-022 COMMIT SHALL update the NUM_DIGITS BCD digit buffer and overflow flag atomically in one cycle; the display SHALL read only the committed buffer (no partially converted digits shown).
REQ-023 Conversion latency LOAD to COMMIT SHALL be VAL_W+1 cycles; the refresh period SHALL be VAL_W+2 cycles.
REQ-024 Overflow SHALL be flagged when the sampled value >= 10^NUM_DIGITS; while flagged, and msg_en=0, every digit SHALL show '-'.
REQ-025 With blank_lz=1, msg_en=0, no overflow: digits above the most significant nonzero digit SHALL be blank; value 0 SHALL show '0' on digit 0 only.
REQ-026 Priority per displayed digit: msg_en (msg_code glyph) > overflow ('-') > leading-zero blank > BCD digit.
REQ-027 msg_en, msg_code, blank_lz and dp_mask SHALL be sampled on the tick that registers the digit; no conversion restart on their change.
REQ-028 Simultaneous tick and COMMIT: the digit registered at that tick SHALL use the pre-commit buffer.

Reset
REQ-029 While rst=1: prescaler=0, pos=0, an=all 1s, seg=FF, BCD buffer=0, overflow=0, converter in IDLE.
REQ-030 In the first cycle after rst falls, the converter SHALL enter LOAD; the first tick SHALL occur DIV cycles after rst falls.
REQ-031 rst asserted mid-conversion or mid-refresh SHALL abort all activity within one cycle and restore REQ-029 values; no stale commit afterward.

Verification (NUM_DIGITS=4, VAL_W=16, DIV=4)
REQ-032 value_a=1234, sel_b=0, blank_lz=0 -> over 4 ticks (an,seg) = (E,99),(D,B0),(B,A4),(7,F9), repeating.
REQ-033 value_a=10000 -> all four digits seg=BF; then value_a=9999 -> all digits 90 after next commit.
REQ-034 value_a=7, blank_lz=1, dp_mask=0001 -> digit0 seg=78, digits1-3 seg=FF; value_a=0 -> digit0 C0, others FF.
REQ-035 msg_en=1, msg_code=0xA05B (digits 3..0 = L,O,S,E) -> digits0..3 seg = 86,92,C0,C7, independent of value.
REQ-036 change value_a 1111->2222 three cycles after LOAD -> display holds 1111 until the following commit, never a mixed digit set.
REQ-037 assert rst for 1 cycle mid-SHIFT -> next cycle an=F, seg=FF, buffer 0; first valid digits after VAL_W+1 cycles plus next tick.
